instr_mem_ctrl: RTL and testbench
=================================

INSTR_MEM_CTRL -- requirements
Module: instr_mem_ctrl

Interface
REQ-001 Parameters (name, default, meaning); all SHALL be overridable at instantiation:
- DATA_WIDTH, 32, instruction word width
- ADDR_WIDTH, 32, fetch byte-address width
- BYTE_WIDTH, 8, byte-lane width; DATA_WIDTH SHALL be a multiple of it
- MEM_DEPTH, 1024, word count; power of two
REQ-002 Derived: NB = DATA_WIDTH/BYTE_WIDTH lanes; OFS = log2(NB); LW = log2(MEM_DEPTH)+OFS load-address width.
REQ-003 Ports (name, direction, width, meaning):
- clk  in  1  single clock; all state updates on its rising edge
- rst_n  in  1  asynchronous, active-low reset
- we  in  1  load-write strobe
- dir  in  LW  load byte address
- data_in  in  DATA_WIDTH  load write data
- be  in  NB  load byte-lane enables
- start  in  1  one-cycle pulse: end of loading, begin fetch
- run  out  1  1 in RUN state
- words_loaded  out  log2(MEM_DEPTH)+1  count of distinct words written
- wr_err  out  1  one-cycle pulse: rejected write
- req_valid  in  1  fetch request valid
- req_ready  out  1  fetch request accepted when high with req_valid
- a  in  ADDR_WIDTH  fetch byte address
- rsp_valid  out  1  fetch response valid
- rsp_ready  in  1  consumer accepts response
- rd  out  DATA_WIDTH  fetched instruction
- rsp_err  out  1  response is an error (misaligned/out-of-range/parity)

Function
REQ-004 FSM has exactly two states, LOAD and RUN; LOAD->RUN on start=1 in LOAD; RUN->LOAD only via reset; start in RUN SHALL be ignored.
REQ-005 In LOAD, we=1 with dir[OFS-1:0]==0 SHALL write lanes with be[i]=1 of word dir>>OFS at the clock edge; lanes with be[i]=0 SHALL keep prior content.
REQ-006 In LOAD, we=1 with dir[OFS-1:0]!=0 SHALL not write and SHALL pulse wr_err the following cycle; any we=1 in RUN SHALL not write and SHALL pulse wr_err.
REQ-007 words_loaded SHALL increment once per first accepted write to each word (per-word written flag), saturating at MEM_DEPTH; rewrites SHALL not increment.
REQ-008 In LOAD, req_ready SHALL be 0; in RUN, req_ready SHALL equal !rsp_valid || rsp_ready.
REQ-009 Accepted request (req_valid && req_ready) SHALL produce rsp_valid=1 on the next cycle (latency 1), with rd = word a>>OFS and rsp_err=0 when legal.
REQ-010 Misaligned a (a[OFS-1:0]!=0) or a >= MEM_DEPTH*NB SHALL respond rsp_err=1, rd=0, same latency.
REQ-011 While rsp_valid=1 and rsp_ready=0, rd, rsp_err and rsp_valid SHALL hold stable; rsp_valid SHALL drop the cycle after handshake unless a new request was accepted that same cycle (back-to-back, one word per cycle).
REQ-012 Start and we in the same LOAD cycle: write SHALL complete, then state becomes RUN.
REQ-013 Memory contents SHALL not be cleared by reset; an unwritten word SHALL read as 0 (initialise array to 0).

Reset
REQ-014 rst_n=0 SHALL immediately force: state LOAD, run=0, words_loaded=0, written flags=0, wr_err=0, req_ready=0, rsp_valid=0, rsp_err=0, rd=0.
REQ-015 Reset asserted mid-handshake SHALL discard the pending response; after release, first fetch requires a new start.

Configuration
REQ-016 Macro INSTR_MEM_PARITY_EN: defined -> one even-parity bit stored per word, computed on the merged written word; fetch of a word whose stored parity mismatches SHALL return rsp_err=1, rd=data. Undefined -> no parity storage, parity never flags errors.

Verification
REQ-017 Load 0x00000513,0x00100593,0x00A00613,0x00060C63 at dir 0,4,8,12 with be=4'hF, start, fetch a=0,4,8,12 with rsp_ready=1 -> rd same words one cycle after each accept, rsp_err=0, words_loaded=4.
REQ-018 Write dir=8, data_in=0xFFFFFFFF, be=4'b0001 over 0x00A00613, fetch a=8 -> rd=0x00A006FF; words_loaded unchanged.
REQ-019 LOAD write dir=6 -> wr_err pulse, no write; RUN write dir=0 -> wr_err pulse, word 0 unchanged.
REQ-020 RUN fetch a=2 -> rsp_err=1, rd=0; fetch a=4096 (MEM_DEPTH=1024) -> rsp_err=1, rd=0.
REQ-021 Fetch a=0 with rsp_ready=0 for 3 cycles -> rsp_valid, rd=0x00000513 held, req_ready=0; rsp_ready=1 -> next request accepted same cycle.
REQ-022 Assert rst_n=0 with rsp_valid=1 -> rsp_valid=0, run=0 immediately; memory still reads 0x00000513 at a=0 after new start.

Source files
------------

// File: rtl/instr_mem_ctrl.sv
// ---------------------------------------------------------------------------
// instr_mem_ctrl
//
// Instruction memory with a load phase and a fetch phase. While in LOAD,
// byte-enabled word writes fill the array. A start pulse moves the block
// into RUN. In RUN it serves fetch requests over a valid/ready handshake
// with one cycle of latency. Only reset returns the block to LOAD, and
// reset leaves the memory contents intact.
//
// Optional feature:
//   INSTR_MEM_PARITY_EN - when defined, one even-parity bit is stored per
//                         word. A fetch whose stored parity does not match
//                         returns rsp_err=1 together with the raw data.
//
// Ports:
//   clk, rst_n        clock, async active-low reset
//   we, dir, data_in, be
//                     load write strobe, byte address, data, lane enables
//   start             end-of-load pulse (LOAD -> RUN)
//   run               high in RUN
//   words_loaded      number of distinct words written since reset
//   wr_err            one-cycle pulse for a rejected write
//   req_valid, req_ready, a
//                     fetch request handshake and byte address
//   rsp_valid, rsp_ready, rd, rsp_err
//                     fetch response handshake, data and error flag
//
// State table:
//   ST_LOAD | memory writable, fetch port closed
//   ST_RUN  | memory read-only, fetch port open
// ---------------------------------------------------------------------------
module instr_mem_ctrl #(
    parameter  int DATA_WIDTH = 32,
    parameter  int ADDR_WIDTH = 32,
    parameter  int BYTE_WIDTH = 8,
    parameter  int MEM_DEPTH  = 1024,
    localparam int NB         = DATA_WIDTH / BYTE_WIDTH,
    localparam int OFS        = $clog2(NB),
    localparam int IW         = $clog2(MEM_DEPTH),
    localparam int LW         = IW + OFS,
    localparam int CW         = IW + 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  we,
    input  logic [LW-1:0]         dir,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic [NB-1:0]         be,
    input  logic                  start,
    output logic                  run,
    output logic [CW-1:0]         words_loaded,
    output logic                  wr_err,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [ADDR_WIDTH-1:0] a,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rd,
    output logic                  rsp_err
);

    typedef enum logic {
        ST_LOAD = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    state_e                  state_q, state_d;
    logic                    run_q;
    logic                    wr_err_q, wr_err_d;
    logic [CW-1:0]           words_q, words_d;
    logic [MEM_DEPTH-1:0]    written_q, written_d;
    logic                    rsp_valid_q, rsp_valid_d;
    logic [DATA_WIDTH-1:0]   rd_q, rd_d;
    logic                    rsp_err_q, rsp_err_d;

    // Memory is not reset: its contents survive rst_n. Power-up value is zero.
    logic [DATA_WIDTH-1:0]   mem_q [MEM_DEPTH] = '{default: '0};

    logic                    wr_misaligned;
    logic                    wr_ok;
    logic [IW-1:0]           wr_idx;
    logic [DATA_WIDTH-1:0]   wr_word;
    logic                    rd_misaligned;
    logic                    rd_out_of_range;
    logic [IW-1:0]           rd_idx;
    logic                    rd_par_err;
    logic                    accept;

    assign wr_misaligned   = (dir & LW'(NB - 1)) != '0;
    assign wr_idx          = IW'(dir >> OFS);
    assign wr_ok           = we && (state_q == ST_LOAD) && !wr_misaligned;

    assign rd_misaligned   = (a & ADDR_WIDTH'(NB - 1)) != '0;
    // Any address bit above the load-address width means the address is past the end of the array.
    assign rd_out_of_range = (a >> LW) != '0;
    assign rd_idx          = IW'(a >> OFS);

    assign req_ready       = (state_q == ST_RUN) && (!rsp_valid_q || rsp_ready);
    assign accept          = req_valid && req_ready;

    // Disabled lanes keep the old bytes. Parity is computed on this merged word.
    always_comb begin
        wr_word = mem_q[wr_idx];
        for (int i = 0; i < NB; i++) begin
            if (be[i]) begin
                wr_word[i*BYTE_WIDTH +: BYTE_WIDTH] = data_in[i*BYTE_WIDTH +: BYTE_WIDTH];
            end
        end
    end

`ifdef INSTR_MEM_PARITY_EN
    logic par_q [MEM_DEPTH] = '{default: 1'b0};

    assign rd_par_err = par_q[rd_idx] != (^mem_q[rd_idx]);

    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem_q[wr_idx] <= wr_word;
            par_q[wr_idx] <= ^wr_word;
        end
    end
`else
    assign rd_par_err = 1'b0;

    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem_q[wr_idx] <= wr_word;
        end
    end
`endif

    always_comb begin
        state_d     = state_q;
        wr_err_d    = we && ((state_q == ST_RUN) || wr_misaligned);
        words_d     = words_q;
        written_d   = written_q;
        rsp_valid_d = rsp_valid_q;
        rd_d        = rd_q;
        rsp_err_d   = rsp_err_q;

        if ((state_q == ST_LOAD) && start) begin
            state_d = ST_RUN;
        end

        if (wr_ok && !written_q[wr_idx]) begin
            written_d[wr_idx] = 1'b1;
            if (words_q != CW'(MEM_DEPTH)) begin
                words_d = words_q + 1'b1;
            end
        end

        if (accept) begin
            rsp_valid_d = 1'b1;
            if (rd_misaligned || rd_out_of_range) begin
                rd_d      = '0;
                rsp_err_d = 1'b1;
            end else begin
                rd_d      = mem_q[rd_idx];
                rsp_err_d = rd_par_err;
            end
        end else if (rsp_ready) begin
            rsp_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_LOAD;
            run_q       <= 1'b0;
            wr_err_q    <= 1'b0;
            words_q     <= '0;
            written_q   <= '0;
            rsp_valid_q <= 1'b0;
            rd_q        <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            run_q       <= (state_d == ST_RUN);
            wr_err_q    <= wr_err_d;
            words_q     <= words_d;
            written_q   <= written_d;
            rsp_valid_q <= rsp_valid_d;
            rd_q        <= rd_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    assign run          = run_q;
    assign wr_err       = wr_err_q;
    assign words_loaded = words_q;
    assign rsp_valid    = rsp_valid_q;
    assign rd           = rd_q;
    assign rsp_err      = rsp_err_q;

endmodule

// File: tb/tb_instr_mem_ctrl.sv
module tb_instr_mem_ctrl;

    localparam int LW = 12;
    localparam int CW = 11;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          we;
    logic [LW-1:0] dir;
    logic [31:0]   data_in;
    logic [3:0]    be;
    logic          start;
    logic          run;
    logic [CW-1:0] words_loaded;
    logic          wr_err;
    logic          req_valid;
    logic          req_ready;
    logic [31:0]   a;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [31:0]   rd;
    logic          rsp_err;

    typedef struct packed {
        logic [31:0] rd;
        logic        err;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;

    instr_mem_ctrl dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .we           (we),
        .dir          (dir),
        .data_in      (data_in),
        .be           (be),
        .start        (start),
        .run          (run),
        .words_loaded (words_loaded),
        .wr_err       (wr_err),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .a            (a),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rd           (rd),
        .rsp_err      (rsp_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: a response is consumed at the edge following a negedge where valid && ready.
    always @(negedge clk) begin
        if (rst_n && rsp_valid && rsp_ready) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_rsp actual=%h expected=none", rd);
            end else begin
                mon_e = sb.pop_front();
                chk("rsp_rd", rd, mon_e.rd);
                chk("rsp_err", 32'(rsp_err), 32'(mon_e.err));
            end
        end
    end

    task automatic wr(input logic [LW-1:0] d, input logic [31:0] dat, input logic [3:0] b,
                      input logic exp_err);
        we = 1'b1; dir = d; data_in = dat; be = b;
        tick();
        we = 1'b0; be = '0;
        chk("wr_err_pulse", 32'(wr_err), 32'(exp_err));
        tick();
        chk("wr_err_drop", 32'(wr_err), 32'd0);
    endtask

    task automatic fetch(input logic [31:0] addr, input logic [31:0] exp_rd, input logic exp_err);
        int n;
        sb.push_back('{rd: exp_rd, err: exp_err});
        req_valid = 1'b1;
        a = addr;
        n = 0;
        while (!req_ready && n < 20) begin
            tick();
            n++;
        end
        chk("req_ready_wait", 32'(req_ready), 32'd1);
        tick();
        req_valid = 1'b0;
        chk("rsp_valid_latency", 32'(rsp_valid), 32'd1);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst_n = 1'b0; we = 1'b0; dir = '0; data_in = '0; be = '0; start = 1'b0;
        req_valid = 1'b0; a = '0; rsp_ready = 1'b0;
        #2;
        chk("rst_run", 32'(run), 32'd0);
        chk("rst_words", 32'(words_loaded), 32'd0);
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rd", rd, 32'd0);
        chk("rst_rsp_err", 32'(rsp_err), 32'd0);
        chk("rst_wr_err", 32'(wr_err), 32'd0);
        tick(); tick();
        rst_n = 1'b1;
        tick();

        // Initial program load
        wr(12'd0,  32'h0000_0513, 4'hF, 1'b0);
        wr(12'd4,  32'h0010_0593, 4'hF, 1'b0);
        wr(12'd8,  32'h00A0_0613, 4'hF, 1'b0);
        wr(12'd12, 32'h0006_0C63, 4'hF, 1'b0);
        chk("words_after_load", 32'(words_loaded), 32'd4);
        wr(12'd6,  32'hDEAD_BEEF, 4'hF, 1'b1);
        chk("words_after_misaligned", 32'(words_loaded), 32'd4);
        chk("load_req_ready", 32'(req_ready), 32'd0);
        pulse_start();
        chk("run_after_start", 32'(run), 32'd1);

        // Back-to-back fetches, including an unwritten word
        rsp_ready = 1'b1;
        fetch(32'd0,  32'h0000_0513, 1'b0);
        fetch(32'd4,  32'h0010_0593, 1'b0);
        fetch(32'd8,  32'h00A0_0613, 1'b0);
        fetch(32'd12, 32'h0006_0C63, 1'b0);
        fetch(32'd16, 32'h0000_0000, 1'b0);
        tick();
        chk("rsp_valid_drop", 32'(rsp_valid), 32'd0);

        // Rejected write in RUN, error fetches, start ignored in RUN
        wr(12'd0, 32'hFFFF_FFFF, 4'hF, 1'b1);
        fetch(32'd0,       32'h0000_0513, 1'b0);
        fetch(32'd2,       32'h0000_0000, 1'b1);
        fetch(32'h0000_1000, 32'h0000_0000, 1'b1);
        fetch(32'h0000_0FFC, 32'h0000_0000, 1'b0);
        tick();
        pulse_start();
        chk("run_start_ignored", 32'(run), 32'd1);

        // Backpressure hold, then release with a waiting request
        rsp_ready = 1'b0;
        fetch(32'd0, 32'h0000_0513, 1'b0);
        sb.push_back('{rd: 32'h0010_0593, err: 1'b0});
        req_valid = 1'b1;
        a = 32'd4;
        for (int i = 0; i < 3; i++) begin
            chk("hold_valid", 32'(rsp_valid), 32'd1);
            chk("hold_rd", rd, 32'h0000_0513);
            chk("hold_req_ready", 32'(req_ready), 32'd0);
            tick();
        end
        rsp_ready = 1'b1;
        #1;
        chk("release_req_ready", 32'(req_ready), 32'd1);
        tick();
        req_valid = 1'b0;
        chk("b2b_valid", 32'(rsp_valid), 32'd1);
        chk("b2b_rd", rd, 32'h0010_0593);
        tick();
        chk("b2b_drop", 32'(rsp_valid), 32'd0);

        // Reset while a response is pending
        rsp_ready = 1'b0;
        fetch(32'd0, 32'h0000_0513, 1'b0);
        rst_n = 1'b0;
        #1;
        chk("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("midrst_run", 32'(run), 32'd0);
        chk("midrst_rd", rd, 32'd0);
        sb.delete();
        tick();
        rst_n = 1'b1;
        tick();
        chk("postrst_words", 32'(words_loaded), 32'd0);
        chk("postrst_req_ready", 32'(req_ready), 32'd0);
        pulse_start();
        rsp_ready = 1'b1;
        fetch(32'd0, 32'h0000_0513, 1'b0);
        tick();

        // Reload after reset: rewrites do not count, then a byte write together with start
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        wr(12'd0,  32'h0000_0513, 4'hF, 1'b0);
        wr(12'd0,  32'h0000_0513, 4'hF, 1'b0);
        chk("words_rewrite", 32'(words_loaded), 32'd1);
        wr(12'd4,  32'h0010_0593, 4'hF, 1'b0);
        wr(12'd8,  32'h00A0_0613, 4'hF, 1'b0);
        wr(12'd12, 32'h0006_0C63, 4'hF, 1'b0);
        chk("words_reload", 32'(words_loaded), 32'd4);
        we = 1'b1; dir = 12'd8; data_in = 32'hFFFF_FFFF; be = 4'b0001; start = 1'b1;
        tick();
        we = 1'b0; be = '0; start = 1'b0;
        chk("start_with_we_run", 32'(run), 32'd1);
        chk("start_with_we_wr_err", 32'(wr_err), 32'd0);
        chk("words_after_byte_wr", 32'(words_loaded), 32'd4);
        fetch(32'd8,  32'h00A0_06FF, 1'b0);
        fetch(32'd12, 32'h0006_0C63, 1'b0);
        tick();

        n = 0;
        while (sb.size() != 0 && n < 50) begin
            tick();
            n++;
        end
        chk("sb_drain", 32'(sb.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
